// File: rtl/corr_time_gen.sv
// corr_time_gen: epoch/timing generator driving corr_ch fix_pulse and irq_pulse.
// Optional PPS alignment is built in when CORR_TIME_PPS_SYNC_EN is defined.
module corr_time_gen #(
    parameter logic [31:0] BASEADDR = 32'd0,
    parameter int          PER_W    = 24,
    parameter int          DIV_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic        fix_pulse,
    output logic        irq_pulse
`ifdef CORR_TIME_PPS_SYNC_EN
    ,
    input  logic        pps_in
`endif
);

    localparam logic [PER_W-1:0] PER_RST = PER_W'(1000);
    localparam logic [PER_W-1:0] PER_MIN = PER_W'(2);

    logic             en;
    logic [PER_W-1:0] pend;
    logic [PER_W-1:0] act;
    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] phase;
    logic [DIV_W-1:0] irq_div;
    logic [DIV_W-1:0] dec;
    logic [31:0]      epoch;

    logic [31:0]      off;
    logic             wr_ctrl;
    logic             wr_per;
    logic             wr_div;
    logic             rd_epoch;
    logic             en_next;
    logic             rise;
    logic             sw_fix;
    logic             wrap;
    logic             fire;
    logic             irq_hit;
    logic [PER_W-1:0] eff_pend;
    logic [31:0]      rd_mux;

    logic             pps_arm;
    logic             pps_seen;
    logic             pps_fire;
    logic             unused_bits;

    assign unused_bits = ^bus_wdata;

    assign off      = bus_addr - BASEADDR;
    assign wr_ctrl  = bus_wr && (off == 32'd0);
    assign wr_per   = bus_wr && (off == 32'd1);
    assign wr_div   = bus_wr && (off == 32'd2);
    assign rd_epoch = bus_rd && (off == 32'd3);

    assign en_next  = wr_ctrl ? bus_wdata[0] : en;
    assign rise     = !en && en_next;
    assign sw_fix   = wr_ctrl && bus_wdata[1] && bus_wdata[0];
    assign wrap     = en && (cnt == act - PER_W'(1));
    // A disabling write always wins, so no pulse leaks out on EN 1->0.
    assign fire     = en && en_next && (wrap || sw_fix || pps_fire);
    assign irq_hit  = (irq_div != '0) && (dec == irq_div - DIV_W'(1));
    assign eff_pend = (pend < PER_MIN) ? PER_MIN : pend;

    // Software-visible configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= 1'b0;
            pend    <= PER_RST;
            irq_div <= '0;
        end else begin
            if (wr_ctrl) en <= bus_wdata[0];
            if (wr_per) pend <= bus_wdata[PER_W-1:0];
            if (wr_div) irq_div <= bus_wdata[DIV_W-1:0];
        end
    end

    // Period counter; active period only reloads at epoch boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            act       <= PER_RST;
            fix_pulse <= 1'b0;
        end else begin
            fix_pulse <= fire;
            if (!en || !en_next || fire) begin
                cnt <= '0;
                act <= eff_pend;
            end else begin
                cnt <= cnt + PER_W'(1);
            end
        end
    end

    // Epoch counter and interrupt decimator
    always_ff @(posedge clk) begin
        if (rst) begin
            epoch     <= '0;
            dec       <= '0;
            irq_pulse <= 1'b0;
        end else begin
            irq_pulse <= fire && irq_hit;
            if (rise) epoch <= '0;
            else if (fire) epoch <= epoch + 32'd1;
            if (wr_div || rise) dec <= '0;
            else if (fire && irq_div != '0) dec <= irq_hit ? '0 : dec + DIV_W'(1);
        end
    end

    // Read data mux
    always_comb begin
        rd_mux = '0;
        case (off)
            32'd0:   rd_mux = {29'd0, pps_arm, 1'b0, en};
            32'd1:   rd_mux = 32'(pend);
            32'd2:   rd_mux = 32'(irq_div);
            32'd3:   rd_mux = epoch;
            32'd4:   rd_mux = 32'(phase);
            32'd5:   rd_mux = {30'd0, pps_seen, en};
            default: rd_mux = '0;
        endcase
    end

    // Registered read port; EPOCH read snapshots the counter into PHASE
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
            phase      <= '0;
        end else begin
            bus_rvalid <= bus_rd;
            bus_rdata  <= bus_rd ? rd_mux : '0;
            if (rd_epoch) phase <= cnt;
        end
    end

`ifdef CORR_TIME_PPS_SYNC_EN
    logic [2:0] pps_sync;
    logic       pps_edge;

    assign pps_edge = pps_sync[1] && !pps_sync[2];
    assign pps_fire = pps_edge && pps_arm && en && !wr_ctrl;

    // Synchronise pps_in and keep one delayed copy for edge detect
    always_ff @(posedge clk) begin
        if (rst) pps_sync <= '0;
        else pps_sync <= {pps_sync[1:0], pps_in};
    end

    // One-shot arm and sticky seen flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pps_arm  <= 1'b0;
            pps_seen <= 1'b0;
        end else if (wr_ctrl) begin
            pps_arm  <= bus_wdata[2];
            pps_seen <= 1'b0;
        end else if (pps_fire) begin
            pps_arm  <= 1'b0;
            pps_seen <= 1'b1;
        end
    end
`else
    assign pps_arm  = 1'b0;
    assign pps_seen = 1'b0;
    assign pps_fire = 1'b0;
`endif

endmodule

// File: tb/tb_corr_time_gen.sv
// tb_corr_time_gen: directed bench for corr_time_gen.
// Pulse cycles and read data are queued ahead and matched as they appear.
module tb_corr_time_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_wr = 1'b0;
    logic        bus_rd = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        fix_pulse;
    logic        irq_pulse;
`ifdef CORR_TIME_PPS_SYNC_EN
    logic        pps_in = 1'b0;
`endif

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int fails = 0;

    int          fix_q[$];
    int          irq_q[$];
    logic [31:0] rd_q[$];
    string       tag_q[$];

    corr_time_gen dut (
        .clk(clk),
        .rst(rst),
        .bus_wr(bus_wr),
        .bus_rd(bus_rd),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_rvalid(bus_rvalid),
        .fix_pulse(fix_pulse),
        .irq_pulse(irq_pulse)
`ifdef CORR_TIME_PPS_SYNC_EN
        ,
        .pps_in(pps_in)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: match pulses and read data against queued expectations
    always @(negedge clk) begin : mon
        int          e;
        logic [31:0] ed;
        string       t;
        if (fix_q.size() > 0 && fix_q[0] < cyc) begin
            chk("fix_missed", 32'(cyc), 32'(fix_q[0]));
            void'(fix_q.pop_front());
        end
        if (fix_pulse === 1'b1) begin
            e = (fix_q.size() > 0) ? fix_q[0] : -1;
            chk("fix_cycle", 32'(cyc), 32'(e));
            if (e == cyc) void'(fix_q.pop_front());
        end
        if (irq_q.size() > 0 && irq_q[0] < cyc) begin
            chk("irq_missed", 32'(cyc), 32'(irq_q[0]));
            void'(irq_q.pop_front());
        end
        if (irq_pulse === 1'b1) begin
            e = (irq_q.size() > 0) ? irq_q[0] : -1;
            chk("irq_cycle", 32'(cyc), 32'(e));
            if (e == cyc) void'(irq_q.pop_front());
        end
        if (bus_rvalid === 1'b1) begin
            if (rd_q.size() > 0) begin
                ed = rd_q.pop_front();
                t  = tag_q.pop_front();
            end else begin
                ed = 32'hDEAD_BEEF;
                t  = "rd_unexpected";
            end
            chk(t, bus_rdata, ed);
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int p);
        p = cyc + 1;
        bus_wr = 1'b1;
        bus_addr = a;
        bus_wdata = d;
        @(negedge clk);
        bus_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] e);
        rd_q.push_back(e);
        tag_q.push_back(tag);
        bus_rd = 1'b1;
        bus_addr = a;
        @(negedge clk);
        bus_rd = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int p;
        int q;
        repeat (3) @(negedge clk);
        chk("rst_fix", 32'(fix_pulse), 32'd0);
        chk("rst_irq", 32'(irq_pulse), 32'd0);
        chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        rst = 1'b0;
        rd(1, "period_rst", 1000);
        rd(0, "ctrl_rst", 0);
        rd(2, "irqdiv_rst", 0);
        rd(3, "epoch_rst", 0);
        rd(5, "status_rst", 0);
        rd(9, "unmapped_rd", 0);

        // PERIOD=10, IRQ_DIV=3, then EN 1->0 at count 7
        wr(1, 10, p);
        wr(2, 3, p);
        wr(0, 1, p);
        for (int k = 1; k <= 10; k++) fix_q.push_back(p + 10 * k);
        irq_q.push_back(p + 30);
        irq_q.push_back(p + 60);
        irq_q.push_back(p + 90);
        wait_until(p + 52);
        rd(3, "epoch_5", 5);
        rd(4, "phase_snap", 2);
        rd(5, "status_en", 1);
        wait_until(p + 107);
        wr(0, 0, q);
        rd(3, "epoch_10", 10);
        rd(4, "phase_off", 0);

        // IRQ_DIV=0 with PERIOD=0 (acts as 2), 50 epochs
        wr(2, 0, p);
        wr(1, 0, p);
        wr(0, 1, p);
        for (int k = 1; k <= 50; k++) fix_q.push_back(p + 2 * k);
        wait_until(p + 101);
        wr(0, 0, q);
        rd(3, "epoch_50", 50);

        // PERIOD=1 (acts as 2)
        wr(1, 1, p);
        wr(0, 1, p);
        for (int k = 1; k <= 5; k++) fix_q.push_back(p + 2 * k);
        wait_until(p + 10);
        wr(0, 0, q);
        rd(3, "epoch_per1", 5);

        // PERIOD change mid-epoch takes effect at next wrap
        wr(1, 10, p);
        wr(0, 1, p);
        fix_q.push_back(p + 10);
        fix_q.push_back(p + 30);
        fix_q.push_back(p + 50);
        wait_until(p + 4);
        wr(1, 20, q);
        wait_until(p + 50);
        wr(0, 0, q);
        rd(1, "period_rb", 20);

        // SW_FIX coincident with wrap, then mid-epoch
        wr(1, 10, p);
        wr(0, 1, p);
        fix_q.push_back(p + 10);
        fix_q.push_back(p + 20);
        fix_q.push_back(p + 24);
        fix_q.push_back(p + 34);
        wait_until(p + 9);
        wr(0, 3, q);
        wait_until(p + 23);
        wr(0, 3, q);
        rd(0, "ctrl_swfix_rd", 1);
        wait_until(p + 34);
        wr(0, 0, q);
        rd(3, "epoch_swfix", 4);
        wr(0, 2, q);
        repeat (12) @(negedge clk);
        wr(7, 32'hFFFF_FFFF, q);
        rd(0, "ctrl_after_unmapped_wr", 0);
        rd(1, "period_after_unmapped_wr", 10);

        // Reset asserted exactly on a would-be wrap
        wr(0, 1, p);
        wait_until(p + 9);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_fix", 32'(fix_pulse), 32'd0);
        chk("midrst_rvalid", 32'(bus_rvalid), 32'd0);
        rst = 1'b0;
        rd(1, "period_after_rst", 1000);
        rd(0, "ctrl_after_rst", 0);
        rd(3, "epoch_after_rst", 0);
        repeat (20) @(negedge clk);

        chk("fix_q_empty", 32'(fix_q.size()), 32'd0);
        chk("irq_q_empty", 32'(irq_q.size()), 32'd0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
